// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction-ROM read port between IF and LS, with IF priority and LS starvation escape.
// Defining ARB_PERF_CNT_EN adds the conflict_cnt_o / ls_starve_evt_o performance counters.
module imem_port_arbiter #(
    parameter int unsigned             DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0]   FIRST_INSTR_ADDR = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0]   LAST_INSTR_ADDR  = 32'hBFC00FFF,
    parameter int unsigned             STARVE_LIMIT     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_err_o,
    input  logic                  ls_req_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  ls_err_o,
    output logic [DATA_WIDTH-1:0] rom_addr_o,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           conflict_cnt_o,
    output logic [31:0]           ls_starve_evt_o,
`endif
    input  logic [DATA_WIDTH-1:0] rom_instr_i
);
    typedef enum logic {IF_PRIO, LS_PRIO} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t                state;
    logic [3:0]            starve_cnt;
    logic [DATA_WIDTH:0]   if_end, ls_end;
    logic                  if_ok, ls_ok, starve_hit;
    assign if_gnt_o   = rst_n && if_req_i && (state == IF_PRIO || !ls_req_i);
    assign ls_gnt_o   = rst_n && ls_req_i && (state == LS_PRIO || !if_req_i);
    assign rom_addr_o = if_gnt_o ? {if_addr_i[DATA_WIDTH-1:2], 2'b00} :
                        ls_gnt_o ? {ls_addr_i[DATA_WIDTH-1:2], 2'b00} : '0;
    // one extra bit so addr+3 cannot wrap back into the window
    assign if_end = {1'b0, if_addr_i} + (DATA_WIDTH+1)'(3);
    assign ls_end = {1'b0, ls_addr_i} + (DATA_WIDTH+1)'(3);
    assign if_ok  = if_addr_i >= FIRST_INSTR_ADDR && if_end <= {1'b0, LAST_INSTR_ADDR};
    assign ls_ok  = ls_addr_i >= FIRST_INSTR_ADDR && ls_end <= {1'b0, LAST_INSTR_ADDR};
    assign starve_hit = state == IF_PRIO && ls_req_i && !ls_gnt_o && starve_cnt + 4'd1 == LIMIT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IF_PRIO;
            starve_cnt  <= '0;
            if_rvalid_o <= 1'b0;
            if_err_o    <= 1'b0;
            if_rdata_o  <= '0;
            ls_rvalid_o <= 1'b0;
            ls_err_o    <= 1'b0;
            ls_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= if_gnt_o;
            if_err_o    <= if_gnt_o && !if_ok;
            if (if_gnt_o) if_rdata_o <= if_ok ? rom_instr_i : '0;
            ls_rvalid_o <= ls_gnt_o;
            ls_err_o    <= ls_gnt_o && !ls_ok;
            if (ls_gnt_o) ls_rdata_o <= ls_ok ? rom_instr_i : '0;
            if (ls_gnt_o || !ls_req_i) begin
                state      <= IF_PRIO;
                starve_cnt <= '0;
            end else if (state == IF_PRIO) begin
                starve_cnt <= starve_cnt == LIMIT ? LIMIT : starve_cnt + 4'd1;
                if (starve_hit) state <= LS_PRIO;
            end
        end
    end
`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_o  <= '0;
            ls_starve_evt_o <= '0;
        end else begin
            if (if_req_i && ls_req_i) conflict_cnt_o <= conflict_cnt_o + 32'd1;
            if (starve_hit) ls_starve_evt_o <= ls_starve_evt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed + randomized check of imem_port_arbiter against a streak-based reference model.
module tb_imem_port_arbiter;
    localparam logic [31:0] FIRST = 32'hBFC00000;
    localparam logic [31:0] LAST  = 32'hBFC00FFF;
    localparam int          LIMIT = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0;
    logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] if_rdata, ls_rdata, rom_addr, rom_instr;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt, starve_evt;
    int          m_conf = 0, m_evt = 0;
`endif
    int          total = 0, bad = 0;
    int          streak = 0;
    logic        ev_if = 1'b0, ee_if = 1'b0, ev_ls = 1'b0, ee_ls = 1'b0;
    logic [31:0] ed_if = '0, ed_ls = '0;
    logic        g_if = 1'b0, g_ls = 1'b0;

    imem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
        .rom_addr_o(rom_addr),
`ifdef ARB_PERF_CNT_EN
        .conflict_cnt_o(conflict_cnt), .ls_starve_evt_o(starve_evt),
`endif
        .rom_instr_i(rom_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
    endfunction
    assign rom_instr = rom_word(rom_addr);

    function automatic bit in_range(input logic [31:0] a);
        return longint'(a) >= longint'(FIRST) && longint'(a) + 3 <= longint'(LAST);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return FIRST + $urandom_range(0, 'hFFF);
            1:       return LAST - $urandom_range(0, 7);
            2:       return FIRST - $urandom_range(1, 8);
            3:       return $urandom;
            default: return FIRST + ($urandom_range(0, 'h3FF) << 2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // LS wins a conflict once it has been refused LIMIT cycles in a row
    task automatic cycle(input bit rst_mid = 1'b0);
        bit          wi, wl;
        logic [31:0] ea;
        @(negedge clk);
        wi = rst_n && if_req && !(ls_req && streak >= LIMIT);
        wl = rst_n && ls_req && !wi;
        ea = wi ? (if_addr & ~32'h3) : wl ? (ls_addr & ~32'h3) : 32'h0;
        check("if_gnt", {31'b0, if_gnt}, {31'b0, wi});
        check("ls_gnt", {31'b0, ls_gnt}, {31'b0, wl});
        check("rom_addr", rom_addr, ea);
        check("if_rvalid", {31'b0, if_rvalid}, {31'b0, ev_if});
        check("if_rdata", if_rdata, ed_if);
        check("if_err", {31'b0, if_err}, {31'b0, ee_if});
        check("ls_rvalid", {31'b0, ls_rvalid}, {31'b0, ev_ls});
        check("ls_rdata", ls_rdata, ed_ls);
        check("ls_err", {31'b0, ls_err}, {31'b0, ee_ls});
`ifdef ARB_PERF_CNT_EN
        check("conflict_cnt", conflict_cnt, 32'(m_conf));
        check("starve_evt", starve_evt, 32'(m_evt));
`endif
        g_if = wi;
        g_ls = wl;
        if (rst_mid) rst_n = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            {ev_if, ee_if, ev_ls, ee_ls} = '0;
            ed_if = '0;
            ed_ls = '0;
            streak = 0;
`ifdef ARB_PERF_CNT_EN
            m_conf = 0;
            m_evt = 0;
`endif
        end else begin
            ev_if = wi;
            ee_if = wi && !in_range(if_addr);
            if (wi) ed_if = in_range(if_addr) ? rom_word(if_addr & ~32'h3) : 32'h0;
            ev_ls = wl;
            ee_ls = wl && !in_range(ls_addr);
            if (wl) ed_ls = in_range(ls_addr) ? rom_word(ls_addr & ~32'h3) : 32'h0;
`ifdef ARB_PERF_CNT_EN
            if (if_req && ls_req) m_conf++;
            if (ls_req && !wl && streak == LIMIT - 1) m_evt++;
`endif
            streak = (ls_req && !wl) ? streak + 1 : 0;
        end
        #1;
    endtask

    initial begin
        if_req = 1'b1; ls_req = 1'b1; if_addr = FIRST; ls_addr = FIRST + 32'd8;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        if_req = 1'b0; ls_req = 1'b0;
        cycle();
        if_req = 1'b1; if_addr = FIRST;
        cycle();
        if_addr = FIRST + 32'd4;
        cycle();
        if_req = 1'b0;
        repeat (2) cycle();
        ls_req = 1'b1; ls_addr = FIRST + 32'd6;
        cycle();
        ls_req = 1'b0;
        cycle();
        if_req = 1'b1; if_addr = 32'h0;
        cycle();
        if_addr = 32'hBFC00FFE;
        cycle();
        if_req = 1'b0;
        cycle();
        if_req = 1'b1; ls_req = 1'b1; if_addr = FIRST + 32'h10; ls_addr = FIRST + 32'h20;
        repeat (7) cycle();
        if_req = 1'b0; ls_req = 1'b0;
        cycle();
        if_req = 1'b1; if_addr = FIRST + 32'h40;
        cycle(1'b1);
        rst_n = 1'b1; if_req = 1'b0;
        repeat (2) cycle();
        if_req = 1'b1; ls_req = 1'b1; if_addr = FIRST + 32'h44; ls_addr = FIRST + 32'h48;
        repeat (4) cycle();
        cycle(1'b1);
        rst_n = 1'b1;
        repeat (2) cycle();
        for (int n = 0; n < 500; n++) begin
            rst_n = 1'b1;
            if (!if_req || g_if) begin
                if_req = $urandom_range(0, 3) != 0;
                if_addr = rand_addr();
            end
            if (!ls_req || g_ls) begin
                ls_req = $urandom_range(0, 1) != 0;
                ls_addr = rand_addr();
            end
            cycle($urandom_range(0, 99) == 0);
        end
        rst_n = 1'b1;
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters: instruction fetch (IF) and load/store constant-pool reads (LS).
- Fixed IF priority, with a starvation counter that hands priority to LS after a bounded wait.
- Registered one-cycle read response per requester.
- Address range check against the ROM window; word-aligns all ROM addresses.

Parameters:
- DATA_WIDTH, 32: address and data width.
- FIRST_INSTR_ADDR, 32'hBFC00000: lowest valid ROM byte address.
- LAST_INSTR_ADDR, 32'hBFC00FFF: highest valid ROM byte address.
- STARVE_LIMIT, 4: consecutive denied LS cycles before LS takes priority (1..15).

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req_i  input  1  IF read request; held with if_addr_i stable until granted.
- if_addr_i  input  DATA_WIDTH  IF byte address.
- if_gnt_o  output  1  IF request accepted this cycle (combinational).
- if_rvalid_o  output  1  IF response valid, one cycle.
- if_rdata_o  output  DATA_WIDTH  IF read word.
- if_err_o  output  1  IF address out of range; qualified by if_rvalid_o.
- ls_req_i  input  1  LS read request; held until granted.
- ls_addr_i  input  DATA_WIDTH  LS byte address.
- ls_gnt_o  output  1  LS request accepted this cycle (combinational).
- ls_rvalid_o  output  1  LS response valid, one cycle.
- ls_rdata_o  output  DATA_WIDTH  LS read word.
- ls_err_o  output  1  LS address out of range; qualified by ls_rvalid_o.
- rom_addr_o  output  DATA_WIDTH  address driven to the ROM (aligned: addr & 32'hFFFFFFFC).
- rom_instr_i  input  DATA_WIDTH  combinational ROM read data.

Behaviour:

Reset:
- All *_rvalid_o, *_err_o and *_rdata_o = 0; state = IF_PRIO; starve_cnt = 0.
- Grants forced 0 while rst_n is low.
- rom_addr_o = 0 when no grant.

Grant rules:
- At most one grant per cycle.
- Grant only when the corresponding req is high.

FSM, state IF_PRIO:
- IF wins a conflict. LS is granted only when if_req_i = 0.
- Each cycle ls_req_i = 1 and ls_gnt_o = 0: starve_cnt += 1, saturating at STARVE_LIMIT.
- When the increment reaches STARVE_LIMIT: next state = LS_PRIO.

FSM, state LS_PRIO:
- LS wins a conflict.
- On any LS grant: state = IF_PRIO and starve_cnt = 0.
- If ls_req_i drops without a grant: state = IF_PRIO and starve_cnt = 0.

Counter clears:
- Any LS grant clears starve_cnt in either state.
- ls_req_i = 0 clears starve_cnt.

Datapath:
- rom_addr_o is the aligned address of the granted requester.
- Latency 1: response registers capture on the grant edge. The following cycle *_rvalid_o = 1 with rdata = rom_instr_i.
- Range check uses the unaligned byte address: FIRST_INSTR_ADDR <= addr and addr+3 <= LAST_INSTR_ADDR.
- Failed check: rdata = 0 and err = 1. A grant and rvalid still occur, so the requester never hangs.
- rdata holds its last value when rvalid = 0. err clears to 0 when rvalid = 0.
- Back-to-back grants to the same requester yield back-to-back rvalid.

Reset mid-operation:
- Asserting rst_n low drops any in-flight response. No rvalid appears after reset release for pre-reset grants.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds output port conflict_cnt_o (32) and output port ls_starve_evt_o (32).
  - conflict_cnt_o counts cycles with both reqs high.
  - ls_starve_evt_o counts IF_PRIO -> LS_PRIO transitions.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent. Arbitration is identical.

Test Plan:
- Reset: rst_n = 0 with both reqs high -> all gnt, rvalid, err and rdata = 0. Release -> IF granted in the first cycle.
- IF only, addresses 0xBFC00000 then 0xBFC00004 on consecutive cycles:
  - rom_addr_o follows the requests.
  - if_rvalid_o high in cycles 2 and 3 with the matching ROM words.
  - ls_* stays idle.
- Misaligned: LS addr 0xBFC00006 -> rom_addr_o = 0xBFC00004; ls_rdata_o = word at 0xBFC00004 one cycle later; ls_err_o = 0.
- Out of range: IF addr 0x00000000, then addr 0xBFC00FFE -> if_gnt_o = 1; next cycle if_rvalid_o = 1, if_err_o = 1, if_rdata_o = 0.
- Starvation, STARVE_LIMIT = 4, both reqs held continuously:
  - IF granted 4 cycles, LS granted on the 5th, then IF resumes.
  - With ARB_PERF_CNT_EN: conflict_cnt_o = 5 and ls_starve_evt_o = 1 after 5 cycles.
- Reset mid-op: grant IF, then pull rst_n low before the response edge -> if_rvalid_o never asserts for that request; state returns to IF_PRIO.
